// File: rtl/lifting_stage.sv
// One predict + one update lifting step of the 9/7 DWT on {odd, even} pairs.
// Pipeline H (pending beat) -> P (odd' and even) -> O (output); stages move together on en.
`timescale 1ns/1ps
module lifting_stage #(
  parameter int DataWidth = 16,
  parameter int CoefWidth = 16,
  parameter int CoefPoint = 12,
  parameter int Lanes     = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [CoefWidth-1:0]           coef_a_i,
  input  logic [CoefWidth-1:0]           coef_b_i,
  output logic                           s_ready_o,
  input  logic                           s_valid_i,
  input  logic                           s_sof_i,
  input  logic                           s_eol_i,
  input  logic [Lanes*2*DataWidth-1:0]   s_data_i,
  input  logic                           m_ready_i,
  output logic                           m_valid_o,
  output logic                           m_sof_o,
  output logic                           m_eol_o,
  output logic [Lanes*2*DataWidth-1:0]   m_data_o,
  output logic                           ovf_o
);

  localparam int PW = DataWidth + CoefWidth + 1;
  localparam int AW = PW + 1;

  typedef logic signed [DataWidth-1:0] samp_t;
  typedef logic signed [CoefWidth-1:0] coef_t;

  // rnd(c * (x + y)): round half up, then arithmetic shift out the coefficient fraction.
  function automatic logic signed [AW-1:0] lift_term(input samp_t x, input samp_t y,
                                                     input coef_t c);
    logic signed [DataWidth:0] s;
    logic signed [AW-1:0]      p;
    s = (DataWidth+1)'(x) + (DataWidth+1)'(y);
    p = AW'(s) * AW'(c);
    p = p + (AW'(1) <<< (CoefPoint-1));
    return p >>> CoefPoint;
  endfunction

  // Returns {saturated, value}.
  function automatic logic [DataWidth:0] sat_add(input samp_t x, input logic signed [AW-1:0] t);
    logic signed [AW-1:0] s;
    logic                 hi_ones;
    logic                 hi_zeros;
    s        = AW'(x) + t;
    hi_ones  = &s[AW-1:DataWidth-1];
    hi_zeros = ~|s[AW-1:DataWidth-1];
    if (hi_ones | hi_zeros) return {1'b0, s[DataWidth-1:0]};
    return {1'b1, s[AW-1], {(DataWidth-1){~s[AW-1]}}};
  endfunction

  logic w_en, w_accept, w_p_fire;

  logic  r_line_start;
  coef_t r_coef_a, r_coef_b;

  logic  r_h_valid, r_h_sof, r_h_eol, r_h_first;
  coef_t r_h_coef_a, r_h_coef_b;
  samp_t r_h_odd [Lanes];
  samp_t r_h_even [Lanes];

  logic  r_p_valid, r_p_sof, r_p_eol, r_p_first, r_p_ovf;
  coef_t r_p_coef_b;
  samp_t r_p_odd [Lanes];
  samp_t r_p_even [Lanes];

  samp_t r_prev_odd [Lanes];
  logic  r_m_valid, r_m_sof, r_m_eol, r_ovf;
  logic [Lanes*2*DataWidth-1:0] r_m_data;

  samp_t w_in_odd [Lanes];
  samp_t w_in_even [Lanes];
  samp_t w_pred_odd [Lanes];
  samp_t w_prev_odd [Lanes];
  samp_t w_upd_even [Lanes];
  logic [Lanes-1:0] w_pred_ovf, w_upd_ovf;
  logic [Lanes*2*DataWidth-1:0] w_o_data;

  assign w_en      = !r_m_valid | m_ready_i;
  assign s_ready_o = w_en & rst_i;
  assign w_accept  = s_valid_i & s_ready_o;
  // An eol beat needs no successor, so it leaves H without waiting for new input.
  assign w_p_fire  = w_en & r_h_valid & (w_accept | r_h_eol);

  always_comb begin
    w_pred_ovf = '0;
    w_upd_ovf  = '0;
    w_o_data   = '0;
    for (int l = 0; l < Lanes; l++) begin
      w_in_even[l] = samp_t'(s_data_i[2*DataWidth*l +: DataWidth]);
      w_in_odd[l]  = samp_t'(s_data_i[2*DataWidth*l + DataWidth +: DataWidth]);
      {w_pred_ovf[l], w_pred_odd[l]} = sat_add(r_h_odd[l],
          lift_term(r_h_even[l], r_h_eol ? r_h_even[l] : w_in_even[l], r_h_coef_a));
      w_prev_odd[l] = r_p_first ? r_p_odd[l] : r_prev_odd[l];
      {w_upd_ovf[l], w_upd_even[l]} = sat_add(r_p_even[l],
          lift_term(w_prev_odd[l], r_p_odd[l], r_p_coef_b));
      w_o_data[2*DataWidth*l +: DataWidth]             = w_upd_even[l];
      w_o_data[2*DataWidth*l + DataWidth +: DataWidth] = r_p_odd[l];
    end
  end

  // Holding stage; each beat carries the coefficients of its own frame down the pipe.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_line_start <= 1'b1;
      r_coef_a     <= '0;
      r_coef_b     <= '0;
      r_h_valid    <= 1'b0;
      r_h_sof      <= 1'b0;
      r_h_eol      <= 1'b0;
      r_h_first    <= 1'b0;
      r_h_coef_a   <= '0;
      r_h_coef_b   <= '0;
      for (int l = 0; l < Lanes; l++) begin
        r_h_odd[l]  <= '0;
        r_h_even[l] <= '0;
      end
    end else if (w_accept) begin
      r_line_start <= s_eol_i;
      if (s_sof_i) begin
        r_coef_a <= coef_a_i;
        r_coef_b <= coef_b_i;
      end
      r_h_valid  <= 1'b1;
      r_h_sof    <= s_sof_i;
      r_h_eol    <= s_eol_i;
      r_h_first  <= r_line_start | s_sof_i;
      r_h_coef_a <= s_sof_i ? coef_t'(coef_a_i) : r_coef_a;
      r_h_coef_b <= s_sof_i ? coef_t'(coef_b_i) : r_coef_b;
      for (int l = 0; l < Lanes; l++) begin
        r_h_odd[l]  <= w_in_odd[l];
        r_h_even[l] <= w_in_even[l];
      end
    end else if (w_p_fire) begin
      r_h_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_p_valid  <= 1'b0;
      r_p_sof    <= 1'b0;
      r_p_eol    <= 1'b0;
      r_p_first  <= 1'b0;
      r_p_ovf    <= 1'b0;
      r_p_coef_b <= '0;
      for (int l = 0; l < Lanes; l++) begin
        r_p_odd[l]  <= '0;
        r_p_even[l] <= '0;
      end
    end else if (w_en) begin
      r_p_valid <= w_p_fire;
      if (w_p_fire) begin
        r_p_sof    <= r_h_sof;
        r_p_eol    <= r_h_eol;
        r_p_first  <= r_h_first;
        r_p_ovf    <= |w_pred_ovf;
        r_p_coef_b <= r_h_coef_b;
        for (int l = 0; l < Lanes; l++) begin
          r_p_odd[l]  <= w_pred_odd[l];
          r_p_even[l] <= r_h_even[l];
        end
      end
    end
  end

  // Output stage; ovf is a single-cycle pulse even when the beat is held by backpressure.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_m_valid <= 1'b0;
      r_m_sof   <= 1'b0;
      r_m_eol   <= 1'b0;
      r_m_data  <= '0;
      r_ovf     <= 1'b0;
      for (int l = 0; l < Lanes; l++) r_prev_odd[l] <= '0;
    end else if (w_en) begin
      r_m_valid <= r_p_valid;
      r_ovf     <= r_p_valid & (r_p_ovf | (|w_upd_ovf));
      if (r_p_valid) begin
        r_m_sof  <= r_p_sof;
        r_m_eol  <= r_p_eol;
        r_m_data <= w_o_data;
        for (int l = 0; l < Lanes; l++) r_prev_odd[l] <= r_p_odd[l];
      end
    end else begin
      r_ovf <= 1'b0;
    end
  end

  assign m_valid_o = r_m_valid;
  assign m_sof_o   = r_m_sof;
  assign m_eol_o   = r_m_eol;
  assign m_data_o  = r_m_data;
  assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_lifting_stage.sv
// Bench for lifting_stage: directed and random frames checked against a line-level model.
`timescale 1ns/1ps
module tb_lifting_stage;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int CP = 12;
  localparam int LN = 4;
  localparam int TW = LN*2*DW;
  localparam int OW = TW + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i = 1'b1;
  logic [CW-1:0] coef_a_i, coef_b_i;
  logic s_ready_o, s_valid_i, s_sof_i, s_eol_i;
  logic [TW-1:0] s_data_i;
  logic m_ready_i, m_valid_o, m_sof_o, m_eol_o, ovf_o;
  logic [TW-1:0] m_data_o;

  lifting_stage #(.DataWidth(DW), .CoefWidth(CW), .CoefPoint(CP), .Lanes(LN)) dut (
    .clk_i(clk), .rst_i(rst_i), .coef_a_i(coef_a_i), .coef_b_i(coef_b_i),
    .s_ready_o(s_ready_o), .s_valid_i(s_valid_i), .s_sof_i(s_sof_i), .s_eol_i(s_eol_i),
    .s_data_i(s_data_i), .m_ready_i(m_ready_i), .m_valid_o(m_valid_o), .m_sof_o(m_sof_o),
    .m_eol_o(m_eol_o), .m_data_o(m_data_o), .ovf_o(ovf_o));

  typedef struct {
    logic          sof;
    logic          eol;
    logic [15:0]   ca;
    logic [15:0]   cb;
    logic [TW-1:0] data;
  } beat_t;

  beat_t         in_q[$];
  logic [OW-1:0] exp_q[$];   // {ovf, sof, eol, data}
  logic [OW-1:0] rx_q[$];
  int            out_cyc_q[$];

  int chk_n = 0, err_n = 0, cyc = 0, first_acc = -1, ovf_pulses = 0;
  bit ready_mode = 0, valid_mode = 0, prev_v = 0, prev_r = 0;
  logic [TW+1:0] prev_out;
  logic lat_ovf = 1'b0;
  int m_a = 0, m_b = 0;
  int g_e[8][LN];
  int g_o[8][LN];

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] want);
    chk_n++;
    assert (obs === want) else begin
      err_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic longint rnd(longint p);
    return (p + (longint'(1) <<< (CP-1))) >>> CP;
  endfunction

  function automatic longint clamp(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: whole-line predict then update with symmetric extension at both ends.
  task automatic push_line(input int len, input bit sof, input int a, input int b);
    longint po[8][LN];
    longint pe[8][LN];
    longint raw, prev, enx;
    bit f[8];
    beat_t bt;
    logic [OW-1:0] ex;
    if (sof) begin m_a = a; m_b = b; end
    for (int n = 0; n < len; n++) begin
      f[n] = 0;
      for (int l = 0; l < LN; l++) begin
        enx = (n == len-1) ? g_e[n][l] : g_e[n+1][l];
        raw = g_o[n][l] + rnd(longint'(m_a) * (g_e[n][l] + enx));
        po[n][l] = clamp(raw);
        if (po[n][l] != raw) f[n] = 1;
      end
    end
    for (int n = 0; n < len; n++) begin
      for (int l = 0; l < LN; l++) begin
        prev = (n == 0) ? po[0][l] : po[n-1][l];
        raw = g_e[n][l] + rnd(longint'(m_b) * (prev + po[n][l]));
        pe[n][l] = clamp(raw);
        if (pe[n][l] != raw) f[n] = 1;
      end
    end
    for (int n = 0; n < len; n++) begin
      bt.sof = sof && (n == 0);
      bt.eol = (n == len-1);
      bt.ca  = bt.sof ? 16'(a) : 16'($urandom);
      bt.cb  = bt.sof ? 16'(b) : 16'($urandom);
      ex = '0;
      for (int l = 0; l < LN; l++) begin
        bt.data[32*l +: 16]      = 16'(g_e[n][l]);
        bt.data[32*l+16 +: 16]   = 16'(g_o[n][l]);
        ex[32*l +: 16]           = 16'(pe[n][l]);
        ex[32*l+16 +: 16]        = 16'(po[n][l]);
      end
      ex[TW+2] = f[n];
      ex[TW+1] = bt.sof;
      ex[TW]   = bt.eol;
      in_q.push_back(bt);
      exp_q.push_back(ex);
    end
  endtask

  task automatic fill_random(input int len, input int span);
    for (int n = 0; n < len; n++)
      for (int l = 0; l < LN; l++) begin
        g_e[n][l] = int'($urandom_range(0, 2*span)) - span;
        g_o[n][l] = int'($urandom_range(0, 2*span)) - span;
      end
  endtask

  task automatic clear_cap();
    rx_q.delete();
    out_cyc_q.delete();
    first_acc = -1;
    ovf_pulses = 0;
  endtask

  // One clock: drive at negedge, check outputs just after, retire accepted input at posedge.
  task automatic step();
    bit acc;
    @(negedge clk);
    if (in_q.size() > 0 && (!valid_mode || $urandom_range(0, 3) != 0)) begin
      s_valid_i = 1'b1;
      s_sof_i   = in_q[0].sof;
      s_eol_i   = in_q[0].eol;
      coef_a_i  = in_q[0].ca;
      coef_b_i  = in_q[0].cb;
      s_data_i  = in_q[0].data;
    end else begin
      s_valid_i = 1'b0;
      s_sof_i   = 1'($urandom_range(0, 1));
      s_eol_i   = 1'($urandom_range(0, 1));
      coef_a_i  = 16'($urandom);
      coef_b_i  = 16'($urandom);
      s_data_i  = {$urandom, $urandom, $urandom, $urandom};
    end
    m_ready_i = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (prev_v && !prev_r) begin
      check("hold_valid", m_valid_o, 1);
      check("hold_data", {m_sof_o, m_eol_o, m_data_o}, prev_out);
      check("ovf_pulse", ovf_o, 0);
    end else if (m_valid_o) begin
      lat_ovf = ovf_o;
    end else begin
      check("ovf_idle", ovf_o, 0);
    end
    if (ovf_o) ovf_pulses++;
    if (m_valid_o && m_ready_i) begin
      rx_q.push_back({lat_ovf, m_sof_o, m_eol_o, m_data_o});
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("extra_out", m_valid_o, 0);
      else check("out_beat", {lat_ovf, m_sof_o, m_eol_o, m_data_o}, exp_q.pop_front());
    end
    prev_v   = m_valid_o;
    prev_r   = m_ready_i;
    prev_out = {m_sof_o, m_eol_o, m_data_o};
    acc = s_valid_i && s_ready_o;
    if (acc && first_acc < 0) first_acc = cyc;
    @(posedge clk);
    if (acc) void'(in_q.pop_front());
    cyc++;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
      step();
      k++;
    end
    check("drain_timeout", in_q.size() + exp_q.size(), 0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    in_q.delete();
    exp_q.delete();
    m_a = 0;
    m_b = 0;
    #1;
    check("rst_ready", s_ready_o, 0);
    check("rst_valid", m_valid_o, 0);
    check("rst_flags", {ovf_o, m_sof_o, m_eol_o}, 0);
    check("rst_data", m_data_o, 0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    prev_v = 0;
    prev_r = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stopped on time limit");
  end

  initial begin
    int t1_o[3];
    int t1_e[3];
    int total;
    beat_t bt;
    s_valid_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0; m_ready_i = 1'b1;
    coef_a_i = '0; coef_b_i = '0; s_data_i = '0;
    t1_o = '{0, 0, 5};
    t1_e = '{10, 20, 31};

    do_reset();
    step();
    check("post_rst_valid", m_valid_o, 0);

    // Two back-to-back three-beat lines, no backpressure.
    ready_mode = 0; valid_mode = 0;
    clear_cap();
    fill_random(3, 1000);
    for (int n = 0; n < 3; n++) begin
      g_e[n][0] = 10 * (n + 1);
      g_o[n][0] = 10 * (n + 1) + 5;
    end
    push_line(3, 1, -2048, 1024);
    push_line(3, 0, 0, 0);
    drain(60);
    check("t1_count", rx_q.size(), 6);
    if (rx_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("t1_odd", rx_q[i][31:16], 16'(t1_o[i % 3]));
        check("t1_even", rx_q[i][15:0], 16'(t1_e[i % 3]));
        check("t1_sof", rx_q[i][TW+1], (i == 0));
        check("t1_eol", rx_q[i][TW], (i % 3 == 2));
      end
      check("t1_first_latency", out_cyc_q[0] - first_acc, 3);
      check("t1_no_bubble", out_cyc_q[5] - out_cyc_q[0], 5);
    end
    check("t1_no_ovf", ovf_pulses, 0);

    // Single-beat line uses both extensions.
    clear_cap();
    fill_random(1, 1000);
    g_e[0][0] = 1; g_o[0][0] = 2;
    push_line(1, 1, 4096, 4096);
    drain(30);
    check("t2_count", rx_q.size(), 1);
    if (rx_q.size() == 1) begin
      check("t2_odd", rx_q[0][31:16], 16'd4);
      check("t2_even", rx_q[0][15:0], 16'd9);
    end

    // Saturation on an eol beat.
    clear_cap();
    fill_random(1, 1000);
    g_e[0][0] = 32767; g_o[0][0] = 32767;
    push_line(1, 1, 4096, 0);
    drain(30);
    check("t3_count", rx_q.size(), 1);
    if (rx_q.size() == 1) begin
      check("t3_odd", rx_q[0][31:16], 16'h7fff);
      check("t3_ovf", rx_q[0][TW+2], 1);
    end
    check("t3_ovf_pulses", ovf_pulses, 1);

    // Random backpressure and input gaps over two frames with different coefficients.
    ready_mode = 1; valid_mode = 1;
    clear_cap();
    total = 0;
    for (int f = 0; f < 2; f++) begin
      int a, b;
      a = int'($urandom_range(0, 12000)) - 6000;
      b = int'($urandom_range(0, 12000)) - 6000;
      for (int ln = 0; ln < 3; ln++) begin
        int len;
        len = int'($urandom_range(1, 6));
        fill_random(len, 16000);
        push_line(len, (ln == 0), a, b);
        total += len;
      end
    end
    drain(2000);
    check("t4_count", rx_q.size(), total);

    // Reset with beats in flight, then fresh lines.
    ready_mode = 0; valid_mode = 0;
    for (int n = 0; n < 2; n++) begin
      bt.sof = (n == 0);
      bt.eol = 1'b0;
      bt.ca  = 16'($urandom);
      bt.cb  = 16'($urandom);
      bt.data = {$urandom, $urandom, $urandom, $urandom};
      in_q.push_back(bt);
    end
    step();
    step();
    do_reset();
    clear_cap();
    fill_random(2, 8000);
    push_line(2, 0, 0, 0);
    drain(40);
    fill_random(2, 8000);
    push_line(2, 1, 3000, -1500);
    drain(40);
    check("t5_count", rx_q.size(), 4);
    if (rx_q.size() == 4) check("t5_sof", rx_q[0][TW+1], 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
    $finish;
  end

endmodule
